// File: rtl/axis_rx_checker.sv
// AXI-Stream receive checker: paces TREADY, measures packet lengths and flags protocol errors.
// Define AXIS_RX_CHECK_STABLE_EN to build the stall-stability (drop / stable) checks.
module axis_rx_checker #(
    parameter int DW         = 32,
    parameter int IDW        = 1,
    parameter int DESTW      = 1,
    parameter int UW         = 1,
    parameter int LGDEPTH    = 16,
    parameter int MAX_PACKET = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic               i_aclk,
    input  logic               i_aresetn,
    input  logic               i_tvalid,
    input  logic               i_tlast,
    input  logic [DW-1:0]      i_tdata,
    input  logic [DW/8-1:0]    i_tstrb,
    input  logic [DW/8-1:0]    i_tkeep,
    input  logic [IDW-1:0]     i_tid,
    input  logic [DESTW-1:0]   i_tdest,
    input  logic [UW-1:0]      i_tuser,
    input  logic               i_ready_en,
    output logic               o_tready,
    output logic               o_pkt_valid,
    output logic [LGDEPTH-1:0] o_pkt_bytes,
    output logic [LGDEPTH-1:0] o_pkt_count,
    output logic               o_err_reserved,
    output logic               o_err_overlen,
    output logic               o_err_drop,
    output logic               o_err_stable
);

    localparam int NB = DW / 8;
    localparam int LW = LGDEPTH + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_PACKET);

    typedef enum logic [1:0] {S_IDLE, S_PKT, S_GAP} state_t;

    state_t             r_state;
    logic               r_ready_q;
    logic [GW-1:0]      r_gap_cnt;
    logic [LGDEPTH-1:0] r_run;
    logic               r_pkt_valid;
    logic [LGDEPTH-1:0] r_pkt_bytes;
    logic [LGDEPTH-1:0] r_pkt_count;
    logic               r_err_res;
    logic               r_err_ovl;

    logic [NB-1:0]      w_valid_mask;
    logic [LW-1:0]      w_beat_bytes;
    logic [LW-1:0]      w_sum;
    logic [LGDEPTH-1:0] w_sum_sat;
    logic               w_accept;
    logic               w_reserved;
    logic               w_overlen;

    assign o_tready     = r_ready_q && i_ready_en;
    assign w_accept     = i_tvalid && o_tready;
    assign w_valid_mask = i_tkeep & i_tstrb;
    assign w_reserved   = i_tvalid && (|(~i_tkeep & i_tstrb));

    always_comb begin
        w_beat_bytes = '0;
        for (int i = 0; i < NB; i++)
            if (i_tvalid && w_valid_mask[i]) w_beat_bytes = w_beat_bytes + 1'b1;
    end

    // One extra bit catches the carry so the count clamps instead of wrapping
    assign w_sum     = {1'b0, r_run} + w_beat_bytes;
    assign w_sum_sat = w_sum[LGDEPTH] ? {LGDEPTH{1'b1}} : w_sum[LGDEPTH-1:0];
    assign w_overlen = (MAX_PACKET > 0) && (w_sum > MAX_LEN);

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_state     <= S_IDLE;
            r_ready_q   <= 1'b0;
            r_gap_cnt   <= '0;
            r_run       <= '0;
            r_pkt_valid <= 1'b0;
            r_pkt_bytes <= '0;
            r_pkt_count <= '0;
            r_err_res   <= 1'b0;
            r_err_ovl   <= 1'b0;
        end else begin
            r_pkt_valid <= 1'b0;
            if (w_reserved) r_err_res <= 1'b1;
            if (w_accept && w_overlen) r_err_ovl <= 1'b1;
            case (r_state)
                S_IDLE, S_PKT: begin
                    // ready_q is only low here in the first cycle after reset
                    r_ready_q <= 1'b1;
                    if (w_accept) begin
                        if (i_tlast) begin
                            r_pkt_valid <= 1'b1;
                            r_pkt_bytes <= w_sum_sat;
                            r_pkt_count <= r_pkt_count + 1'b1;
                            r_run       <= '0;
                            if (GAP_CYCLES > 0) begin
                                r_state   <= S_GAP;
                                r_ready_q <= 1'b0;
                                r_gap_cnt <= GAP_LOAD;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_run   <= w_sum_sat;
                            r_state <= S_PKT;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state   <= S_IDLE;
                        r_ready_q <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_pkt_valid    = r_pkt_valid;
    assign o_pkt_bytes    = r_pkt_bytes;
    assign o_pkt_count    = r_pkt_count;
    assign o_err_reserved = r_err_res;
    assign o_err_overlen  = r_err_ovl;

`ifdef AXIS_RX_CHECK_STABLE_EN
    logic               r_prev_stall;
    logic               r_p_last;
    logic [NB-1:0]      r_p_keep;
    logic [NB-1:0]      r_p_strb;
    logic [IDW-1:0]     r_p_id;
    logic [DESTW-1:0]   r_p_dest;
    logic [UW-1:0]      r_p_user;
    logic [DW-1:0]      r_p_data;
    logic               r_err_drop;
    logic               r_err_stb;
    logic               w_data_diff;
    logic               w_side_diff;

    // Null bytes (keep low) may legally change while stalled
    always_comb begin
        w_data_diff = 1'b0;
        for (int i = 0; i < NB; i++)
            if (i_tkeep[i] && (i_tdata[8*i +: 8] != r_p_data[8*i +: 8])) w_data_diff = 1'b1;
    end

    assign w_side_diff = (i_tlast != r_p_last) || (i_tkeep != r_p_keep) ||
                         (i_tstrb != r_p_strb) || (i_tid != r_p_id) ||
                         (i_tdest != r_p_dest) || (i_tuser != r_p_user);

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_prev_stall <= 1'b0;
            r_err_drop   <= 1'b0;
            r_err_stb    <= 1'b0;
        end else begin
            r_prev_stall <= i_tvalid && !o_tready;
            if (r_prev_stall) begin
                if (!i_tvalid) r_err_drop <= 1'b1;
                else if (w_data_diff || w_side_diff) r_err_stb <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        r_p_last <= i_tlast;
        r_p_keep <= i_tkeep;
        r_p_strb <= i_tstrb;
        r_p_id   <= i_tid;
        r_p_dest <= i_tdest;
        r_p_user <= i_tuser;
        r_p_data <= i_tdata;
    end

    assign o_err_drop   = r_err_drop;
    assign o_err_stable = r_err_stb;
`else
    logic w_unused_stable;
    assign w_unused_stable = ^{i_tid, i_tdest, i_tuser, i_tdata};
    assign o_err_drop      = 1'b0;
    assign o_err_stable    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_rx_checker.sv
// Bench for axis_rx_checker: three configurations share one stimulus stream,
// each tracked by a packet-level reference model.
module tb_axis_rx_checker;

`ifdef AXIS_RX_CHECK_STABLE_EN
    localparam bit STB_EN = 1'b1;
`else
    localparam bit STB_EN = 1'b0;
`endif
    localparam int M_GAP[3] = '{0, 3, 1};
    localparam int M_MAX[3] = '{8, 0, 0};
    localparam int M_SAT[3] = '{65535, 65535, 15};
    localparam int M_MOD[3] = '{65536, 65536, 16};

    logic        clk = 1'b0;
    logic        rstn, valid, last, ready_en;
    logic [31:0] data;
    logic [3:0]  keep, strb;
    logic [0:0]  id, dest, user;
    logic [2:0]  tready, pv, eres, eovl, edrop, estb;
    logic [15:0] pb0, pb1, pc0, pc1;
    logic [3:0]  pb2, pc2;
    logic [15:0] pbv[3], pcv[3];

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    bit m_rdy[3], m_pv[3], m_res[3], m_ovl[3], m_drop[3], m_stb[3], m_pst[3];
    int m_left[3], m_run[3], m_pb[3], m_pc[3];
    logic [31:0] p_data;
    logic        p_last;
    logic [3:0]  p_keep, p_strb;
    logic [0:0]  p_id, p_dest, p_user;

    always #5 clk = ~clk;

    assign pbv[0] = pb0;
    assign pbv[1] = pb1;
    assign pbv[2] = {12'd0, pb2};
    assign pcv[0] = pc0;
    assign pcv[1] = pc1;
    assign pcv[2] = {12'd0, pc2};

    axis_rx_checker #(.DW(32), .LGDEPTH(16), .MAX_PACKET(8), .GAP_CYCLES(0)) u_dut_a (
        .i_aclk(clk), .i_aresetn(rstn), .i_tvalid(valid), .i_tlast(last), .i_tdata(data),
        .i_tstrb(strb), .i_tkeep(keep), .i_tid(id), .i_tdest(dest), .i_tuser(user),
        .i_ready_en(ready_en), .o_tready(tready[0]), .o_pkt_valid(pv[0]), .o_pkt_bytes(pb0),
        .o_pkt_count(pc0), .o_err_reserved(eres[0]), .o_err_overlen(eovl[0]),
        .o_err_drop(edrop[0]), .o_err_stable(estb[0]));

    axis_rx_checker #(.DW(32), .LGDEPTH(16), .MAX_PACKET(0), .GAP_CYCLES(3)) u_dut_b (
        .i_aclk(clk), .i_aresetn(rstn), .i_tvalid(valid), .i_tlast(last), .i_tdata(data),
        .i_tstrb(strb), .i_tkeep(keep), .i_tid(id), .i_tdest(dest), .i_tuser(user),
        .i_ready_en(ready_en), .o_tready(tready[1]), .o_pkt_valid(pv[1]), .o_pkt_bytes(pb1),
        .o_pkt_count(pc1), .o_err_reserved(eres[1]), .o_err_overlen(eovl[1]),
        .o_err_drop(edrop[1]), .o_err_stable(estb[1]));

    axis_rx_checker #(.DW(32), .LGDEPTH(4), .MAX_PACKET(0), .GAP_CYCLES(1)) u_dut_c (
        .i_aclk(clk), .i_aresetn(rstn), .i_tvalid(valid), .i_tlast(last), .i_tdata(data),
        .i_tstrb(strb), .i_tkeep(keep), .i_tid(id), .i_tdest(dest), .i_tuser(user),
        .i_ready_en(ready_en), .o_tready(tready[2]), .o_pkt_valid(pv[2]), .o_pkt_bytes(pb2),
        .o_pkt_count(pc2), .o_err_reserved(eres[2]), .o_err_overlen(eovl[2]),
        .o_err_drop(edrop[2]), .o_err_stable(estb[2]));

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit tr, chg;
            int b, s;
            tr = m_rdy[k] && ready_en;
            if (!rstn) begin
                m_rdy[k] = 0; m_left[k] = 0; m_run[k] = 0; m_pb[k] = 0; m_pc[k] = 0;
                m_pv[k] = 0; m_res[k] = 0; m_ovl[k] = 0; m_drop[k] = 0; m_stb[k] = 0; m_pst[k] = 0;
            end else begin
                m_pv[k] = 0;
                if (STB_EN && m_pst[k]) begin
                    if (!valid) m_drop[k] = 1;
                    else begin
                        chg = (last !== p_last) || (keep !== p_keep) || (strb !== p_strb) ||
                              (id !== p_id) || (dest !== p_dest) || (user !== p_user);
                        for (int i = 0; i < 4; i++)
                            if (keep[i] && (data[8*i +: 8] !== p_data[8*i +: 8])) chg = 1;
                        if (chg) m_stb[k] = 1;
                    end
                end
                m_pst[k] = valid && !tr;
                b = valid ? $countones(keep & strb) : 0;
                if (valid && ((~keep & strb) != 4'd0)) m_res[k] = 1;
                if (valid && tr) begin
                    s = m_run[k] + b;
                    if (M_MAX[k] > 0 && s > M_MAX[k]) m_ovl[k] = 1;
                    if (s > M_SAT[k]) s = M_SAT[k];
                    if (last) begin
                        m_pb[k] = s;
                        m_pc[k] = (m_pc[k] + 1) % M_MOD[k];
                        m_pv[k] = 1;
                        m_run[k] = 0;
                        if (M_GAP[k] > 0) begin m_rdy[k] = 0; m_left[k] = M_GAP[k]; end
                        else m_rdy[k] = 1;
                    end else begin
                        m_run[k] = s;
                    end
                end else if (!m_rdy[k]) begin
                    if (m_left[k] <= 1) begin m_left[k] = 0; m_rdy[k] = 1; end
                    else m_left[k] = m_left[k] - 1;
                end
            end
        end
        p_data = data; p_last = last; p_keep = keep; p_strb = strb;
        p_id = id; p_dest = dest; p_user = user;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        valid = 0; last = 0; keep = 4'hF; strb = 4'hF; data = 32'd0;
        id = 1'b0; dest = 1'b0; user = 1'b0; ready_en = 1;
    endtask

    task automatic do_reset();
        set_idle();
        rstn = 0; tick(); tick();
        rstn = 1; tick();
    endtask

    task automatic test_reset();
        set_idle();
        valid = 1; rstn = 0;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({tready[k], pv[k], eres[k], eovl[k], edrop[k], estb[k], pbv[k], pcv[k]} !== 38'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d] got tready=%b pv=%b bytes=%0d count=%0d errs=%b%b%b%b exp all 0",
                         k, tready[k], pv[k], pbv[k], pcv[k], eres[k], eovl[k], edrop[k], estb[k]);
            end
        end
        valid = 0; rstn = 1; #1;
        n_chk++;
        if (tready !== 3'b000) begin n_fail++; $display("FAIL reset_release_tready got %b exp 000", tready); end
        tick();
        n_chk++;
        if (tready !== 3'b111) begin n_fail++; $display("FAIL reset_ready_rise got %b exp 111", tready); end
    endtask

    task automatic test_three_beats();
        do_reset();
        valid = 1; tick(); tick();
        last = 1; tick();
        n_chk++;
        if (pv[0] !== 1'b1 || pb0 !== 16'd12 || pc0 !== 16'd1) begin
            n_fail++; $display("FAIL three_beats got pv=%b bytes=%0d count=%0d exp 1/12/1", pv[0], pb0, pc0);
        end
        n_chk++;
        if (eovl !== 3'b001) begin n_fail++; $display("FAIL three_beats_overlen got %b exp 001", eovl); end
        valid = 0; last = 0; tick();
        n_chk++;
        if (pv[0] !== 1'b0 || pb0 !== 16'd12) begin
            n_fail++; $display("FAIL three_beats_hold got pv=%b bytes=%0d exp 0/12", pv[0], pb0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        valid = 1; last = 1; tick();
        n_chk++;
        if (pv[0] !== 1'b1 || tready[0] !== 1'b1 || pc0 !== 16'd1) begin
            n_fail++; $display("FAIL b2b_first got pv=%b tready=%b count=%0d exp 1/1/1", pv[0], tready[0], pc0);
        end
        keep = 4'h3; strb = 4'h3; tick();
        n_chk++;
        if (pv[0] !== 1'b1 || pb0 !== 16'd2 || pc0 !== 16'd2) begin
            n_fail++; $display("FAIL b2b_second got pv=%b bytes=%0d count=%0d exp 1/2/2", pv[0], pb0, pc0);
        end
        set_idle(); tick();
    endtask

    task automatic test_gap();
        do_reset();
        valid = 1; last = 1; tick();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (tready[1] !== (i == 3)) begin
                n_fail++; $display("FAIL gap3_tready step %0d got %b exp %b", i, tready[1], (i == 3));
            end
            if (i < 2) begin
                n_chk++;
                if (tready[2] !== (i == 1)) begin
                    n_fail++; $display("FAIL gap1_tready step %0d got %b exp %b", i, tready[2], (i == 1));
                end
            end
            if (i < 3) tick();
        end
        last = 0; tick();
        last = 1; tick();
        n_chk++;
        if (pv[1] !== 1'b1 || pb1 !== 16'd8 || pc1 !== 16'd2) begin
            n_fail++; $display("FAIL gap_next_pkt got pv=%b bytes=%0d count=%0d exp 1/8/2", pv[1], pb1, pc1);
        end
        set_idle(); tick();
    endtask

    task automatic test_overlen();
        do_reset();
        valid = 1; tick(); tick();
        last = 1; keep = 4'h1; strb = 4'h1; tick();
        n_chk++;
        if (eovl[0] !== 1'b1 || pb0 !== 16'd9 || eovl[1] !== 1'b0) begin
            n_fail++; $display("FAIL overlen_9 got ovl=%b bytes=%0d ovl_nomax=%b exp 1/9/0", eovl[0], pb0, eovl[1]);
        end
        do_reset();
        valid = 1; tick();
        last = 1; tick();
        n_chk++;
        if (eovl[0] !== 1'b0 || pb0 !== 16'd8) begin
            n_fail++; $display("FAIL overlen_exact8 got ovl=%b bytes=%0d exp 0/8", eovl[0], pb0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        valid = 1;
        repeat (4) tick();
        last = 1; tick();
        n_chk++;
        if (pbv[2] !== 16'd15 || pbv[0] !== 16'd20 || pcv[2] !== 16'd1) begin
            n_fail++; $display("FAIL saturate got lg4=%0d lg16=%0d count=%0d exp 15/20/1", pbv[2], pbv[0], pcv[2]);
        end
        set_idle(); tick();
    endtask

    task automatic test_reserved();
        do_reset();
        keep = 4'h7; tick();
        n_chk++;
        if (eres !== 3'b000) begin n_fail++; $display("FAIL reserved_novalid got %b exp 000", eres); end
        ready_en = 0; valid = 1; tick();
        n_chk++;
        if (eres !== 3'b111 || pc0 !== 16'd0) begin
            n_fail++; $display("FAIL reserved_set got %b count=%0d exp 111/0", eres, pc0);
        end
        set_idle(); tick(); tick(); tick();
        n_chk++;
        if (eres !== 3'b111) begin n_fail++; $display("FAIL reserved_sticky got %b exp 111", eres); end
        rstn = 0; tick();
        n_chk++;
        if (eres !== 3'b000) begin n_fail++; $display("FAIL reserved_clear got %b exp 000", eres); end
        rstn = 1; tick();
    endtask

    task automatic test_stable();
        do_reset();
        ready_en = 0; valid = 1; keep = 4'hE; strb = 4'hE; data = 32'h11223344;
        tick(); tick();
        data = 32'h11223345; tick();
        n_chk++;
        if (estb !== 3'b000) begin n_fail++; $display("FAIL stable_nullbyte got %b exp 000", estb); end
        do_reset();
        ready_en = 0; valid = 1; data = 32'h11223344;
        tick(); tick();
        n_chk++;
        if (estb !== 3'b000) begin n_fail++; $display("FAIL stable_held got %b exp 000", estb); end
        data = 32'h11223345; tick();
        n_chk++;
        if (estb !== {3{STB_EN}} || edrop !== 3'b000) begin
            n_fail++; $display("FAIL stable_change got stb=%b drop=%b exp %b/000", estb, edrop, {3{STB_EN}});
        end
        do_reset();
        ready_en = 0; valid = 1; data = 32'h11223344;
        tick(); tick();
        valid = 0; tick();
        n_chk++;
        if (edrop !== {3{STB_EN}} || estb !== 3'b000) begin
            n_fail++; $display("FAIL stable_drop got drop=%b stb=%b exp %b/000", edrop, estb, {3{STB_EN}});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid = 1; tick(); tick();
        rstn = 0; valid = 0; tick();
        n_chk++;
        if (pv !== 3'b000 || pc0 !== 16'd0) begin
            n_fail++; $display("FAIL midreset_discard got pv=%b count=%0d exp 000/0", pv, pc0);
        end
        rstn = 1; tick();
        n_chk++;
        if (pv !== 3'b000) begin n_fail++; $display("FAIL midreset_nopulse got %b exp 000", pv); end
        valid = 1; last = 1; tick();
        n_chk++;
        if (pv[0] !== 1'b1 || pb0 !== 16'd4 || pc0 !== 16'd1) begin
            n_fail++; $display("FAIL midreset_next got pv=%b bytes=%0d count=%0d exp 1/4/1", pv[0], pb0, pc0);
        end
        set_idle(); tick();
    endtask

    task automatic test_random();
        logic [37:0] got, exp;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rstn = ($urandom_range(0, 299) != 0);
            ready_en = ($urandom_range(0, 7) != 0);
            if (!(valid && $urandom_range(0, 3) != 0)) begin
                valid = ($urandom_range(0, 3) != 0);
                last  = ($urandom_range(0, 4) == 0);
                keep  = 4'($urandom);
                strb  = ($urandom_range(0, 39) == 0) ? 4'($urandom) : (keep & 4'($urandom));
                data  = $urandom;
                id    = 1'($urandom); dest = 1'($urandom); user = 1'($urandom);
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                got = {tready[k], pv[k], eres[k], eovl[k], edrop[k], estb[k], pbv[k], pcv[k]};
                exp = {m_rdy[k] && ready_en, m_pv[k], m_res[k], m_ovl[k], m_drop[k], m_stb[k],
                       16'(m_pb[k]), 16'(m_pc[k])};
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random[%0d] cyc %0d got %h exp %h", k, cyc, got, exp);
                end
            end
        end
        set_idle(); tick();
    endtask

    initial begin
        set_idle();
        rstn = 0;
        test_reset();
        test_three_beats();
        test_back_to_back();
        test_gap();
        test_overlen();
        test_saturation();
        test_reserved();
        test_stable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
